// File: rtl/trigger_burst_generator.sv
// Trigger burst generator: synchronises an asynchronous trigger level and
// detects its rising edge. Each accepted trigger starts a burst of evenly
// spaced one-cycle sample strobes. Triggers that arrive during a burst are
// queued in a saturating pending counter, with a sticky overflow flag for
// triggers lost while that counter is full.
module trigger_burst_generator #(
    parameter int SYNC_STAGES  = 2,
    parameter int LEN_WIDTH    = 8,
    parameter int PERIOD_WIDTH = 16,
    parameter int PEND_WIDTH   = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    pulseIn,
    input  logic                    enable,
    input  logic [LEN_WIDTH-1:0]    burstLength,
    input  logic [PERIOD_WIDTH-1:0] period,
    input  logic                    clearOverflow,
    output logic                    sampleStrobe,
    output logic                    busy,
    output logic [PEND_WIDTH-1:0]   pending,
    output logic                    overflow,
    output logic [15:0]             triggerCount
);

    // A synchroniser needs at least two flops for metastability settling.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [PERIOD_WIDTH-1:0] PERIOD_ONE = PERIOD_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]    LEN_ONE    = LEN_WIDTH'(1);
    localparam logic [PEND_WIDTH-1:0]   PEND_ONE   = PEND_WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;

    // Saturating increment of the pending-trigger queue depth.
    function automatic logic [PEND_WIDTH-1:0] sat_inc(input logic [PEND_WIDTH-1:0] v);
        return (&v) ? v : v + PEND_ONE;
    endfunction

    logic [SYNC_N-1:0] sync_p;
    logic [SYNC_N-1:0] vld_p;
    logic              prev_p;
    logic              armed;
    logic              trig;

    state_t                  state, state_n;
    logic [PERIOD_WIDTH-1:0] timer, timer_n;
    logic [PERIOD_WIDTH-1:0] period_eff, period_eff_n;
    logic [LEN_WIDTH-1:0]    remaining, remaining_n;
    logic [PEND_WIDTH-1:0]   pending_n;
    logic                    overflow_n;
    logic [15:0]             count_n;
    logic                    strobe_n;
    logic                    ovf_event;
    logic                    accept;
    logic                    last_tick;
    logic [PERIOD_WIDTH-1:0] period_ld;

    // Synchroniser chain, then registered edge detector.
    // vld_p marks when the last sync stage holds a genuine post-reset
    // sample. The detector only arms after it has seen that sample low,
    // so a level held high across reset release cannot fire a trigger.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_p <= '0;
            vld_p  <= '0;
            prev_p <= 1'b0;
            armed  <= 1'b0;
            trig   <= 1'b0;
        end else begin
            sync_p <= {sync_p[SYNC_N-2:0], pulseIn};
            vld_p  <= {vld_p[SYNC_N-2:0], 1'b1};
            prev_p <= sync_p[SYNC_N-1];
            armed  <= armed | (vld_p[SYNC_N-1] & ~sync_p[SYNC_N-1]);
            trig   <= sync_p[SYNC_N-1] & ~prev_p & armed;
        end
    end

    assign accept    = trig & enable;
    assign period_ld = (period == '0) ? PERIOD_ONE : period;
    assign last_tick = (timer == period_eff - PERIOD_ONE);
    assign busy      = (state == RUN);

    // Next-state and datapath update for the burst sequencer.
    always_comb begin
        state_n      = state;
        timer_n      = timer;
        period_eff_n = period_eff;
        remaining_n  = remaining;
        pending_n    = pending;
        strobe_n     = 1'b0;
        ovf_event    = 1'b0;
        count_n      = accept ? triggerCount + 16'd1 : triggerCount;

        case (state)
            IDLE: begin
                // A zero-length burst only counts the trigger.
                if (accept && (burstLength != '0)) begin
                    state_n      = RUN;
                    remaining_n  = burstLength;
                    period_eff_n = period_ld;
                    timer_n      = '0;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_n     = IDLE;
                    pending_n   = '0;
                    timer_n     = '0;
                    remaining_n = '0;
                end else if (last_tick) begin
                    strobe_n    = 1'b1;
                    timer_n     = '0;
                    remaining_n = remaining - LEN_ONE;
                    if (remaining == LEN_ONE) begin
                        if (accept || (pending != '0)) begin
                            // A trigger landing on the final strobe starts the
                            // next burst directly, so the queue depth is unchanged.
                            if (!accept) begin
                                pending_n = pending - PEND_ONE;
                            end
                            if (burstLength != '0) begin
                                remaining_n  = burstLength;
                                period_eff_n = period_ld;
                            end else begin
                                // Queued bursts of length zero have nothing to emit.
                                state_n   = IDLE;
                                pending_n = '0;
                            end
                        end else begin
                            state_n = IDLE;
                        end
                    end else if (accept) begin
                        ovf_event = &pending;
                        pending_n = sat_inc(pending);
                    end
                end else begin
                    timer_n = timer + PERIOD_ONE;
                    if (accept) begin
                        ovf_event = &pending;
                        pending_n = sat_inc(pending);
                    end
                end
            end
        endcase

        // A new overflow event takes priority over a simultaneous clear.
        overflow_n = ovf_event | (overflow & ~clearOverflow);
    end

    // State and datapath registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            timer        <= '0;
            period_eff   <= PERIOD_ONE;
            remaining    <= '0;
            pending      <= '0;
            overflow     <= 1'b0;
            triggerCount <= '0;
            sampleStrobe <= 1'b0;
        end else begin
            state        <= state_n;
            timer        <= timer_n;
            period_eff   <= period_eff_n;
            remaining    <= remaining_n;
            pending      <= pending_n;
            overflow     <= overflow_n;
            triggerCount <= count_n;
            sampleStrobe <= strobe_n;
        end
    end

endmodule

// File: tb/tb_trigger_burst_generator.sv
// Directed testbench for trigger_burst_generator.
// Edge numbers below count posedges from the first posedge that samples
// pulseIn high ("base"). A trigger is accepted three edges after base, so
// the first strobe lands at base + 3 + periodEff.
module tb_trigger_burst_generator;

    logic        clock = 1'b0;
    logic        reset;
    logic        pulseIn;
    logic        enable;
    logic [7:0]  burstLength;
    logic [15:0] period;
    logic        clearOverflow;
    logic        sampleStrobe;
    logic        busy;
    logic [3:0]  pending;
    logic        overflow;
    logic [15:0] triggerCount;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int busyCnt  = 0;
    int base     = 0;
    int sq[$];

    trigger_burst_generator dut (
        .clock        (clock),
        .reset        (reset),
        .pulseIn      (pulseIn),
        .enable       (enable),
        .burstLength  (burstLength),
        .period       (period),
        .clearOverflow(clearOverflow),
        .sampleStrobe (sampleStrobe),
        .busy         (busy),
        .pending      (pending),
        .overflow     (overflow),
        .triggerCount (triggerCount)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock; sample outputs 1 time unit after the edge and log strobes.
    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
        if (sampleStrobe === 1'b1) sq.push_back(cyc);
        if (busy === 1'b1) busyCnt++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) step();
    endtask

    function automatic int qat(input int i);
        if (i < sq.size()) return sq[i];
        return -1;
    endfunction

    initial begin
        reset = 1'b0; pulseIn = 1'b0; enable = 1'b0;
        burstLength = 8'd0; period = 16'd0; clearOverflow = 1'b0;

        // Reset state
        step(); step();
        chk("rst_strobe",  sampleStrobe, 0);
        chk("rst_busy",    busy, 0);
        chk("rst_pending", pending, 0);
        chk("rst_ovf",     overflow, 0);
        chk("rst_count",   triggerCount, 0);
        reset = 1'b1;
        repeat (6) step();

        // Basic burst: length 3, period 4, pulse high 5 samples.
        // Inputs changed mid-burst must not alter it.
        enable = 1'b1; burstLength = 8'd3; period = 16'd4;
        sq.delete(); busyCnt = 0;
        pulseIn = 1'b1; step(); base = cyc;
        repeat (4) step();
        pulseIn = 1'b0; burstLength = 8'd7; period = 16'd2;
        run_to(base + 14);
        chk("b1_busy_before_last", busy, 1);
        chk("b1_nstrobe_before_last", sq.size(), 2);
        step();
        chk("b1_last_strobe", sampleStrobe, 1);
        chk("b1_busy_drop", busy, 0);
        run_to(base + 30);
        chk("b1_nstrobe", sq.size(), 3);
        chk("b1_s0", qat(0), base + 7);
        chk("b1_s1", qat(1), base + 11);
        chk("b1_s2", qat(2), base + 15);
        chk("b1_busy_cycles", busyCnt, 12);
        chk("b1_count", triggerCount, 1);

        // period 0 acts as 1: four back-to-back strobes
        burstLength = 8'd4; period = 16'd0;
        sq.delete(); busyCnt = 0;
        pulseIn = 1'b1; step(); base = cyc;
        step(); pulseIn = 1'b0;
        run_to(base + 3);
        chk("p0_busy_start", busy, 1);
        chk("p0_no_strobe_yet", sampleStrobe, 0);
        run_to(base + 15);
        chk("p0_nstrobe", sq.size(), 4);
        chk("p0_first", qat(0), base + 4);
        chk("p0_last",  qat(3), base + 7);
        chk("p0_busy_cycles", busyCnt, 4);
        chk("p0_count", triggerCount, 2);

        // Second trigger aligned with final strobe of a length-1 burst
        burstLength = 8'd1; period = 16'd3;
        sq.delete(); busyCnt = 0;
        pulseIn = 1'b1; step(); base = cyc;
        pulseIn = 1'b0; step(); step();
        pulseIn = 1'b1; step();
        pulseIn = 1'b0;
        run_to(base + 6);
        chk("al_strobe", sampleStrobe, 1);
        chk("al_pending", pending, 0);
        chk("al_busy", busy, 1);
        run_to(base + 20);
        chk("al_nstrobe", sq.size(), 2);
        chk("al_second", qat(1), base + 9);
        chk("al_busy_cycles", busyCnt, 6);
        chk("al_count", triggerCount, 4);

        // enable dropped after first strobe with one trigger pending
        burstLength = 8'd5; period = 16'd3;
        sq.delete();
        pulseIn = 1'b1; step(); base = cyc;
        pulseIn = 1'b0; step();
        pulseIn = 1'b1; step();
        pulseIn = 1'b0;
        run_to(base + 6);
        chk("en_first_strobe", sampleStrobe, 1);
        chk("en_pending_before", pending, 1);
        enable = 1'b0;
        step();
        chk("en_busy_off", busy, 0);
        chk("en_pending_clr", pending, 0);
        chk("en_no_strobe", sampleStrobe, 0);
        run_to(base + 25);
        chk("en_nstrobe", sq.size(), 1);
        chk("en_count", triggerCount, 6);

        // Trigger with enable low is discarded
        sq.delete();
        pulseIn = 1'b1; step(); step();
        pulseIn = 1'b0;
        repeat (15) step();
        chk("dis_count", triggerCount, 6);
        chk("dis_busy", busy, 0);
        chk("dis_nstrobe", sq.size(), 0);

        // Pending saturation: length 2, period 10, 20 triggers two cycles apart.
        // Accepts at base+3,5,..,41; burst ends at +23 (coinciding trigger) and
        // +43. Pending fills to 15 at +35; +37,+39,+41 are lost. 17 bursts total,
        // the last strobe at base + 23 + 16*20.
        enable = 1'b1; burstLength = 8'd2; period = 16'd10;
        sq.delete();
        for (int j = 0; j < 40; j++) begin
            pulseIn = (j % 2 == 0);
            clearOverflow = (j == 39);
            step();
            if (j == 0) base = cyc;
            if (j == 35) chk("ov_not_yet", overflow, 0);
            if (j == 37) begin
                chk("ov_set", overflow, 1);
                chk("ov_pending_full", pending, 15);
            end
        end
        chk("ov_clear_collide", overflow, 1);
        pulseIn = 1'b0; clearOverflow = 1'b0;
        run_to(base + 41);
        chk("ov_pending_sat", pending, 15);
        chk("ov_count", triggerCount, 26);
        clearOverflow = 1'b1; step(); clearOverflow = 1'b0;
        chk("ov_cleared", overflow, 0);
        run_to(base + 360);
        chk("ov_nstrobe", sq.size(), 34);
        chk("ov_last_strobe", qat(33), base + 343);
        chk("ov_idle", busy, 0);
        chk("ov_pending_drained", pending, 0);

        // Reset mid-burst with pulseIn held high across release
        burstLength = 8'd5; period = 16'd3;
        sq.delete();
        pulseIn = 1'b1; step(); base = cyc;
        run_to(base + 6);
        chk("rb_strobe_before", sampleStrobe, 1);
        reset = 1'b0;
        #1;
        chk("rb_strobe", sampleStrobe, 0);
        chk("rb_busy", busy, 0);
        chk("rb_count", triggerCount, 0);
        chk("rb_pending", pending, 0);
        chk("rb_ovf", overflow, 0);
        repeat (3) step();
        reset = 1'b1;
        sq.delete();
        repeat (20) step();
        chk("rb_no_strobe", sq.size(), 0);
        chk("rb_no_trig", triggerCount, 0);
        chk("rb_idle", busy, 0);
        pulseIn = 1'b0;
        repeat (3) step();
        pulseIn = 1'b1; step(); base = cyc;
        repeat (2) step();
        pulseIn = 1'b0;
        run_to(base + 12);
        chk("rb_retrig_count", triggerCount, 1);
        chk("rb_retrig_first", qat(0), base + 6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
